// File: rtl/l1_pkg.sv
// rtl/l1_pkg.sv - shared types and default geometry for the L1 refill controller
package l1_pkg;

    localparam int L1_ADDR_WIDTH = 32;
    localparam int L1_DATA_WIDTH = 32;
    localparam int L1_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// rtl/l1_refill_ctrl_if.sv - miss, L2 read and data/tag array signals of the refill controller
interface l1_refill_ctrl_if
    import l1_pkg::*;
#(
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int DATA_WIDTH = L1_DATA_WIDTH,
    parameter int LINE_WORDS = L1_LINE_WORDS
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                  miss_req;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  miss_ack;
    logic                  l2_req;
    logic [ADDR_WIDTH-1:0] l2_addr;
    logic                  l2_gnt;
    logic                  l2_rvalid;
    logic [DATA_WIDTH-1:0] l2_rdata;
    logic                  arr_we;
    logic [IDX_W-1:0]      arr_idx;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  tag_we;
    logic                  refill_done;

    // slave: the refill controller; master: the core engine, L2 and arrays around it
    modport slave (
        input  miss_req, miss_addr, l2_gnt, l2_rvalid, l2_rdata,
        output miss_ack, l2_req, l2_addr, arr_we, arr_idx, arr_wdata, tag_we, refill_done
    );

    modport master (
        output miss_req, miss_addr, l2_gnt, l2_rvalid, l2_rdata,
        input  miss_ack, l2_req, l2_addr, arr_we, arr_idx, arr_wdata, tag_we, refill_done
    );

endinterface

// File: rtl/l1_refill_ctrl.sv
// rtl/l1_refill_ctrl.sv - L1 line refill: accept miss, request line from L2, write beats, install tag
module l1_refill_ctrl
    import l1_pkg::*;
#(
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int DATA_WIDTH = L1_DATA_WIDTH,
    parameter int LINE_WORDS = L1_LINE_WORDS
) (
    input  logic           clk,
    input  logic           rst,
    l1_refill_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);

    refill_state_e         state;
    refill_state_e         state_nx;
    logic [IDX_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_beat;

    assign last_beat = (cnt == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.miss_req) addr_q <= {bus.miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                REQ:  cnt <= '0;
                FILL: if (bus.l2_rvalid) cnt <= cnt + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.miss_req) state_nx = REQ;
            REQ:  if (bus.l2_gnt) state_nx = FILL;
            FILL: if (bus.l2_rvalid && last_beat) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so an abandoned line never sees another write
    always_comb begin
        bus.miss_ack    = 1'b0;
        bus.l2_req      = 1'b0;
        bus.l2_addr     = '0;
        bus.arr_we      = 1'b0;
        bus.arr_idx     = '0;
        bus.arr_wdata   = '0;
        bus.tag_we      = 1'b0;
        bus.refill_done = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: bus.miss_ack = bus.miss_req;
                REQ: begin
                    bus.l2_req  = 1'b1;
                    bus.l2_addr = addr_q;
                end
                FILL: begin
                    if (bus.l2_rvalid) begin
                        bus.arr_we    = 1'b1;
                        bus.arr_idx   = cnt;
                        bus.arr_wdata = bus.l2_rdata;
                        bus.tag_we    = last_beat;
                    end
                end
                DONE: bus.refill_done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb/tb_l1_refill_ctrl.sv - self-checking bench for l1_refill_ctrl
module tb_l1_refill_ctrl;
    import l1_pkg::*;

    localparam int LW         = L1_LINE_WORDS;
    localparam int LINE_BYTES = L1_LINE_WORDS * L1_DATA_WIDTH / 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    l1_refill_ctrl_if bus ();

    l1_refill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_miss_ack"}, bus.miss_ack, 0);
        chk({tag, "_l2_req"}, bus.l2_req, 0);
        chk({tag, "_l2_addr"}, bus.l2_addr, 0);
        chk({tag, "_arr_we"}, bus.arr_we, 0);
        chk({tag, "_arr_idx"}, bus.arr_idx, 0);
        chk({tag, "_arr_wdata"}, bus.arr_wdata, 0);
        chk({tag, "_tag_we"}, bus.tag_we, 0);
        chk({tag, "_refill_done"}, bus.refill_done, 0);
    endtask

    // One refill from the miss_ack cycle onwards; pat[i] is the rvalid of fill cycle i, all ones past pat_len
    task automatic refill(input logic [31:0] addr, input int gnt_dly, input logic [31:0] pat,
                          input int pat_len, input bit keep_req, input bit fixed_data, input int abort_beats);
        logic [31:0] line;
        logic [31:0] data [LW];
        int          beat;
        int          cyc;
        bit          v;
        line = addr & ~32'(LINE_BYTES - 1);
        for (int k = 0; k < LW; k++) data[k] = fixed_data ? 32'hA0 + 32'(k) : $urandom;

        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        bus.l2_gnt    = 1'b0;
        bus.l2_rvalid = 1'b0;
        #1;
        chk("ack", bus.miss_ack, 1);
        chk("ack_l2_req", bus.l2_req, 0);
        tick();
        bus.miss_req = keep_req;

        for (int i = 0; i <= gnt_dly; i++) begin
            bus.l2_gnt    = (i == gnt_dly);
            bus.l2_rvalid = 1'($urandom);
            bus.l2_rdata  = $urandom;
            #1;
            chk("req_l2_req", bus.l2_req, 1);
            chk("req_l2_addr", bus.l2_addr, line);
            chk("req_arr_we", bus.arr_we, 0);
            chk("req_miss_ack", bus.miss_ack, 0);
            tick();
        end

        beat = 0;
        cyc  = 0;
        while (beat < LW) begin
            if (abort_beats != 0 && beat == abort_beats) begin
                rst           = 1'b1;
                bus.l2_rvalid = 1'b1;
                bus.l2_rdata  = $urandom;
                bus.l2_gnt    = 1'b0;
                #1;
                chk("rst_tag_we", bus.tag_we, 0);
                chk("rst_refill_done", bus.refill_done, 0);
                tick();
                rst           = 1'b0;
                bus.miss_req  = 1'b0;
                bus.l2_gnt    = 1'b1;
                #1;
                chk_idle("post_rst");
                tick();
                bus.l2_rvalid = 1'b0;
                bus.l2_gnt    = 1'b0;
                #1;
                chk_idle("post_rst2");
                tick();
                return;
            end
            v = (cyc < pat_len) ? pat[cyc] : 1'b1;
            bus.l2_rvalid = v;
            bus.l2_gnt    = 1'($urandom);
            bus.l2_rdata  = v ? data[beat] : $urandom;
            #1;
            chk("fill_arr_we", bus.arr_we, v);
            if (v) begin
                chk("fill_arr_idx", bus.arr_idx, beat);
                chk("fill_arr_wdata", bus.arr_wdata, data[beat]);
                chk("fill_tag_we", bus.tag_we, beat == LW - 1);
            end else begin
                chk("gap_tag_we", bus.tag_we, 0);
            end
            chk("fill_l2_req", bus.l2_req, 0);
            chk("fill_miss_ack", bus.miss_ack, 0);
            chk("fill_refill_done", bus.refill_done, 0);
            beat += int'(v);
            cyc++;
            tick();
            if (cyc > 64) begin
                chk("fill_timeout", 1, 0);
                return;
            end
        end

        bus.l2_rvalid = 1'b1;
        bus.l2_gnt    = 1'b1;
        #1;
        chk("done_pulse", bus.refill_done, 1);
        chk("done_arr_we", bus.arr_we, 0);
        chk("done_tag_we", bus.tag_we, 0);
        chk("done_miss_ack", bus.miss_ack, 0);
        tick();
        bus.l2_rvalid = 1'b0;
        bus.l2_gnt    = 1'b0;
        if (!keep_req) begin
            #1;
            chk("after_done_pulse", bus.refill_done, 0);
            chk("after_done_l2_req", bus.l2_req, 0);
            chk("after_done_miss_ack", bus.miss_ack, 0);
            tick();
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.miss_req  = 1'b0;
        bus.miss_addr = '0;
        bus.l2_gnt    = 1'b0;
        bus.l2_rvalid = 1'b0;
        bus.l2_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_idle("reset");

        // stray beats and grants while idle
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.l2_rvalid = 1'b1;
            bus.l2_gnt    = 1'b1;
            bus.l2_rdata  = $urandom;
            #1;
            chk_idle("stray_idle");
        end
        tick();

        // basic refill, immediate grant, back-to-back beats
        refill(32'h0000_1234, 0, 32'h0, 0, 1'b0, 1'b1, 0);
        // delayed grant and gappy data 1,0,0,1,1,0,1
        refill(32'h0000_ABCD, 5, 32'h59, 7, 1'b0, 1'b0, 0);
        // miss held across DONE, then the next line
        refill(32'h1000_0008, 0, 32'h0, 0, 1'b1, 1'b0, 0);
        refill(32'h2000_00F4, 1, 32'h5, 3, 1'b0, 1'b0, 0);
        // reset after three beats, then a normal refill
        refill(32'h0000_5678, 1, 32'h0, 0, 1'b0, 1'b0, 3);
        refill(32'h0000_9ABC, 0, 32'h0, 0, 1'b0, 1'b1, 0);

        for (int n = 0; n < 16; n++) begin
            refill($urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 8),
                   (n != 15) && 1'($urandom), 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
